// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch/decode types and queue defaults
package fetch_queue_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  exc_adel;
  } fetch_entry_t;
  localparam int FQ_DEPTH = 8;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push, decode-side pop and flush bundle
interface fetch_queue_if import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH
) ();
  localparam int PTR_W = $clog2(DEPTH);
  logic               flush;
  logic [1:0]         in_valid;
  fetch_entry_t       in_entry0;
  fetch_entry_t       in_entry1;
  logic               in_ready;
  logic [1:0]         out_valid;
  fetch_entry_t       out_entry0;
  fetch_entry_t       out_entry1;
  logic [1:0]         out_pop;
  logic [PTR_W:0]     count;
  modport master (
    output flush, in_valid, in_entry0, in_entry1, out_pop,
    input  in_ready, out_valid, out_entry0, out_entry1, count
  );
  modport slave (
    input  flush, in_valid, in_entry0, in_entry1, out_pop,
    output in_ready, out_valid, out_entry0, out_entry1, count
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: unreset entry array, two write and two combinational read ports
module fetch_queue_mem import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic [AW-1:0] wa0,
  input  logic         we0,
  input  fetch_entry_t wd0,
  input  logic [AW-1:0] wa1,
  input  logic         we1,
  input  fetch_entry_t wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output fetch_entry_t rd0,
  output fetch_entry_t rd1
);
  fetch_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide instruction queue between fetch and decode, flushed on redirect
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          resetn,
  fetch_queue_if.slave q
);
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   cnt;
  logic [1:0]       push_n, pop_n;
  logic             pop0, pop1;
  assign q.count     = cnt;
  assign q.in_ready  = cnt <= (PTR_W+1)'(DEPTH - 2);
  assign q.out_valid = {cnt >= (PTR_W+1)'(2), cnt != '0};
  assign push_n      = (q.in_ready & q.in_valid[0]) ? (q.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  // pops are masked by occupancy so count can never underflow
  assign pop0        = q.out_pop[0] & q.out_valid[0];
  assign pop1        = pop0 & q.out_pop[1] & q.out_valid[1];
  assign pop_n       = pop1 ? 2'd2 : {1'b0, pop0};
  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk (clk),
    .wa0 (tail),
    .we0 (~q.flush & (push_n != 2'd0)),
    .wd0 (q.in_entry0),
    .wa1 (tail + PTR_W'(1)),
    .we1 (~q.flush & (push_n == 2'd2)),
    .wd1 (q.in_entry1),
    .ra0 (head),
    .ra1 (head + PTR_W'(1)),
    .rd0 (q.out_entry0),
    .rd1 (q.out_entry1)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(pop_n);
      tail <= tail + PTR_W'(push_n);
      cnt  <= cnt + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end
  a_in_valid: assert property (@(posedge clk) disable iff (!resetn) q.in_valid != 2'b10);
  a_pop_order: assert property (@(posedge clk) disable iff (!resetn) !(q.out_pop[1] & ~q.out_pop[0]));
  a_pop_valid: assert property (@(posedge clk) disable iff (!resetn) (q.out_pop & ~q.out_valid) == 2'b00);
  a_count: assert property (@(posedge clk) disable iff (!resetn)
    cnt <= (PTR_W+1)'(DEPTH) && PTR_W'(tail - head) == cnt[PTR_W-1:0]);
endmodule
